// File: rtl/mackerel_bus_controller_if.sv
// CPU-side bus bundle for the Mackerel 68000 bus controller.
// The master side is the CPU/MFP stimulus; the slave side is the controller.
interface mackerel_bus_controller_if #(
  parameter int unsigned NUM_RAM = 4
) ();
  logic [6:0]         ADDR;
  logic [2:0]         ALO;
  logic [2:0]         FC;
  logic               AS;
  logic               DTACK_MFP;
  logic               ROMEN;
  logic               MFPEN;
  logic               USBEN;
  logic               SEREN;
  logic [NUM_RAM-1:0] RAMEN;
  logic               DTACK;
  logic               BERR;
  logic               VPA;
  logic               IACK;
  logic               BOOT;
  logic               CLK_SLOW;

  modport master (
    output ADDR, ALO, FC, AS, DTACK_MFP,
    input  ROMEN, MFPEN, USBEN, SEREN, RAMEN, DTACK, BERR, VPA, IACK, BOOT, CLK_SLOW
  );

  modport slave (
    input  ADDR, ALO, FC, AS, DTACK_MFP,
    output ROMEN, MFPEN, USBEN, SEREN, RAMEN, DTACK, BERR, VPA, IACK, BOOT, CLK_SLOW
  );
endinterface

// File: rtl/mackerel_bus_controller.sv
// 68000 bus controller: address decode, wait-state DTACK, bus-error watchdog,
// interrupt-acknowledge steering with autovector fallback and a boot ROM overlay.
module mackerel_bus_controller #(
  parameter int unsigned NUM_RAM      = 4,
  parameter int unsigned BOOT_CYCLES  = 8,
  parameter int unsigned ROM_WS       = 2,
  parameter int unsigned RAM_WS       = 0,
  parameter int unsigned IO_WS        = 4,
  parameter int unsigned BERR_TIMEOUT = 64,
  parameter logic [2:0]  MFP_IPL      = 3'd5,
  parameter int unsigned CLK_DIV      = 2
) (
  input logic                      CLK,
  input logic                      RST,
  mackerel_bus_controller_if.slave bus
);

  localparam int unsigned WsW  = 8;
  localparam int unsigned TmrW = $clog2(BERR_TIMEOUT) + 1;
  localparam int unsigned BcW  = $clog2(BOOT_CYCLES + 1);
  localparam int unsigned Half = CLK_DIV / 2;
  localparam int unsigned DivW = (Half > 1) ? $clog2(Half) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StAck, StErr} state_e;
  typedef enum logic [2:0] {RgNone, RgRom, RgRam, RgMfp, RgIo, RgAuto} region_e;

  state_e             state_q;
  region_e            region_q, region;
  logic [WsW-1:0]     wait_q, ws_sel;
  logic [TmrW-1:0]    timer_q;
  logic               dtack_q, berr_q, vpa_q;
  logic               boot_q, as_q;
  logic [BcW-1:0]     boot_cnt_q;
  logic [DivW-1:0]    div_q;
  logic               slow_q;
  logic [NUM_RAM-1:0] ram_en_n;

  logic       as_act, iack_cyc, cpu_sel, lvl_mfp, ack_ready;
  logic       rom_hit, mfp_hit, usb_hit, ser_hit, ram_hit;
  logic [1:0] bank;

  assign iack_cyc = (bus.FC == 3'b111);
  assign lvl_mfp  = (bus.ALO == MFP_IPL);
  assign as_act   = ~bus.AS & RST;
  assign cpu_sel  = as_act & ~iack_cyc;
  assign bank     = bus.ADDR[5:4];

  // While the overlay is active every address lands in ROM and nothing else decodes.
  assign rom_hit = ~boot_q | (bus.ADDR == 7'h7F);
  assign mfp_hit = boot_q & (bus.ADDR == 7'h7E);
  assign usb_hit = boot_q & (bus.ADDR == 7'h7D);
  assign ser_hit = boot_q & (bus.ADDR == 7'h7C);
  assign ram_hit = boot_q & ~bus.ADDR[6] & ({30'd0, bank} < NUM_RAM);

  assign bus.ROMEN = ~(cpu_sel & rom_hit);
  assign bus.MFPEN = ~(as_act & ((~iack_cyc & mfp_hit) | (iack_cyc & lvl_mfp)));
  assign bus.USBEN = ~(cpu_sel & usb_hit);
  assign bus.SEREN = ~(cpu_sel & ser_hit);
  assign bus.RAMEN = ram_en_n;
  assign bus.IACK  = ~(iack_cyc & RST);

  always_comb begin
    ram_en_n = '1;
    for (int unsigned i = 0; i < NUM_RAM; i++) begin
      if (cpu_sel && ram_hit && (bank == 2'(i))) ram_en_n[i] = 1'b0;
    end
  end

  always_comb begin
    region = RgNone;
    if (iack_cyc)     region = lvl_mfp ? RgMfp : RgAuto;
    else if (rom_hit) region = RgRom;
    else if (mfp_hit) region = RgMfp;
    else if (usb_hit || ser_hit) region = RgIo;
    else if (ram_hit) region = RgRam;
  end

  always_comb begin
    ws_sel = '0;
    case (region)
      RgRom:   ws_sel = WsW'(ROM_WS);
      RgRam:   ws_sel = WsW'(RAM_WS);
      RgIo:    ws_sel = WsW'(IO_WS);
      default: ws_sel = '0;
    endcase
  end

  always_comb begin
    ack_ready = 1'b0;
    case (region_q)
      RgRom, RgRam, RgIo: ack_ready = (wait_q == '0);
      RgMfp:              ack_ready = ~bus.DTACK_MFP;
      RgAuto:             ack_ready = 1'b1;
      default:            ack_ready = 1'b0;
    endcase
  end

  // Cycle FSM; the strobes are registered so only one can ever be low.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= StIdle;
      region_q <= RgNone;
      wait_q   <= '0;
      timer_q  <= '0;
      dtack_q  <= 1'b1;
      berr_q   <= 1'b1;
      vpa_q    <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (!bus.AS) begin
            region_q <= region;
            wait_q   <= ws_sel;
            timer_q  <= '0;
            state_q  <= StWait;
          end
        end
        StWait: begin
          if (bus.AS) begin
            state_q <= StIdle;
          end else if (ack_ready) begin
            state_q <= StAck;
            if (region_q == RgAuto) vpa_q <= 1'b0;
            else                    dtack_q <= 1'b0;
          end else if (timer_q == TmrW'(BERR_TIMEOUT - 1)) begin
            state_q <= StErr;
            berr_q  <= 1'b0;
          end else begin
            timer_q <= timer_q + TmrW'(1);
            if (wait_q != '0) wait_q <= wait_q - WsW'(1);
          end
        end
        StAck, StErr: begin
          if (bus.AS) begin
            state_q <= StIdle;
            dtack_q <= 1'b1;
            berr_q  <= 1'b1;
            vpa_q   <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // A bus cycle completes on the first edge that samples AS high after it was low.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      as_q       <= 1'b1;
      boot_cnt_q <= '0;
      boot_q     <= 1'b0;
    end else begin
      as_q <= bus.AS;
      if (bus.AS && !as_q && !boot_q) begin
        boot_cnt_q <= boot_cnt_q + BcW'(1);
        if (boot_cnt_q == BcW'(BOOT_CYCLES - 1)) boot_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_q  <= '0;
      slow_q <= 1'b0;
    end else if (div_q == DivW'(Half - 1)) begin
      div_q  <= '0;
      slow_q <= ~slow_q;
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

  assign bus.DTACK    = dtack_q;
  assign bus.BERR     = berr_q;
  assign bus.VPA      = vpa_q;
  assign bus.BOOT     = boot_q;
  assign bus.CLK_SLOW = slow_q;

endmodule

// File: tb/tb_mackerel_bus_controller.sv
// Directed bench for mackerel_bus_controller: a cycle-level timing model checked
// every clock, plus literal latency/enable expectations for each scenario.
module tb_mackerel_bus_controller;

  localparam int unsigned NUM_RAM      = 4;
  localparam int          BOOT_CYCLES  = 8;
  localparam int          ROM_WS       = 2;
  localparam int          RAM_WS       = 0;
  localparam int          IO_WS        = 4;
  localparam int          TIMEOUT      = 64;
  localparam logic [2:0]  IPL          = 3'd5;
  localparam int          CLK_DIV      = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mackerel_bus_controller_if #(.NUM_RAM(NUM_RAM)) bus ();

  mackerel_bus_controller #(
    .NUM_RAM(NUM_RAM), .BOOT_CYCLES(BOOT_CYCLES), .ROM_WS(ROM_WS), .RAM_WS(RAM_WS),
    .IO_WS(IO_WS), .BERR_TIMEOUT(TIMEOUT), .MFP_IPL(IPL), .CLK_DIV(CLK_DIV)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- cycle-level model ----------------
  bit m_busy = 0, m_auto = 0, m_mfp = 0, m_as_prev = 1;
  int m_n = 0, m_ack_at = -1, m_boots = 0, m_edges = 0;

  function automatic bit m_boot();
    return m_boots >= BOOT_CYCLES;
  endfunction

  // Edges after cycle start at which the acknowledge appears; -1 = external/never.
  function automatic int ack_at_for();
    logic [21:0] a;
    a = {bus.ADDR, 15'd0};
    if (bus.FC == 3'b111) return (bus.ALO == IPL) ? -1 : 1;
    if (!m_boot()) return 1 + ROM_WS;
    if (a == 22'h3F8000) return 1 + ROM_WS;
    if (a == 22'h3E8000 || a == 22'h3E0000) return 1 + IO_WS;
    if (a < 22'h200000 && (a / 22'h80000) < NUM_RAM) return 1 + RAM_WS;
    return -1;
  endfunction

  function automatic bit mfp_cycle();
    if (bus.FC == 3'b111) return bus.ALO == IPL;
    return m_boot() && ({bus.ADDR, 15'd0} == 22'h3F0000);
  endfunction

  // {ROMEN, MFPEN, USBEN, SEREN, RAMEN[3:0]}
  function automatic logic [7:0] exp_en();
    logic [7:0]  e;
    logic [21:0] a;
    int          b;
    e = 8'hFF;
    a = {bus.ADDR, 15'd0};
    b = int'(a / 22'h80000);
    if (rst_n && !bus.AS) begin
      if (bus.FC == 3'b111) begin
        if (bus.ALO == IPL) e[6] = 1'b0;
      end else if (!m_boot()) e[7] = 1'b0;
      else if (a == 22'h3F8000) e[7] = 1'b0;
      else if (a == 22'h3F0000) e[6] = 1'b0;
      else if (a == 22'h3E8000) e[5] = 1'b0;
      else if (a == 22'h3E0000) e[4] = 1'b0;
      else if (a < 22'h200000 && b < NUM_RAM) e[b] = 1'b0;
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_auto = 0; m_mfp = 0; m_as_prev = 1;
      m_n = 0; m_ack_at = -1; m_boots = 0; m_edges = 0;
    end else begin
      m_edges++;
      if (!m_busy) begin
        if (!bus.AS) begin
          m_busy   = 1;
          m_n      = 0;
          m_auto   = (bus.FC == 3'b111) && (bus.ALO != IPL);
          m_mfp    = mfp_cycle();
          m_ack_at = ack_at_for();
        end
      end else begin
        m_n++;
        if (bus.AS) m_busy = 0;
        else if (m_mfp && m_ack_at < 0 && !bus.DTACK_MFP) m_ack_at = m_n;
      end
      if (bus.AS && !m_as_prev && m_boots < BOOT_CYCLES) m_boots++;
      m_as_prev = bus.AS;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit acked, errd;
      logic [7:0] got_en;
      acked = m_busy && m_ack_at >= 0 && m_ack_at <= TIMEOUT && m_n >= m_ack_at;
      errd  = m_busy && !acked && m_n >= TIMEOUT;
      got_en = {bus.ROMEN, bus.MFPEN, bus.USBEN, bus.SEREN, bus.RAMEN};
      check("DTACK", bus.DTACK, !(acked && !m_auto));
      check("VPA", bus.VPA, !(acked && m_auto));
      check("BERR", bus.BERR, !errd);
      check("BOOT", bus.BOOT, m_boot());
      check("CLK_SLOW", bus.CLK_SLOW, (m_edges / (CLK_DIV / 2)) % 2);
      check("enables", got_en, exp_en());
      check("IACK", bus.IACK, !(rst_n && bus.FC == 3'b111));
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] en_snap;
  logic [2:0] strobe_snap;  // {DTACK, BERR, VPA}

  task automatic run_cycle(input logic [6:0] a, input logic [2:0] fc, input logic [2:0] alo,
                           input int mfp_at, input bit release_as, output int lat);
    @(posedge clk); #2;
    bus.ADDR = a; bus.FC = fc; bus.ALO = alo; bus.DTACK_MFP = 1'b1; bus.AS = 1'b0;
    lat = -1;
    @(posedge clk); #1;
    for (int i = 1; i <= 100 && lat < 0; i++) begin
      if (i == mfp_at) bus.DTACK_MFP = 1'b0;
      @(posedge clk); #1;
      if (!bus.DTACK || !bus.BERR || !bus.VPA) begin
        lat = i;
        en_snap = {bus.ROMEN, bus.MFPEN, bus.USBEN, bus.SEREN, bus.RAMEN};
        strobe_snap = {bus.DTACK, bus.BERR, bus.VPA};
      end
    end
    if (lat < 0) check("strobe_timeout", 0, 1);
    if (release_as) begin
      bus.AS = 1'b1; bus.DTACK_MFP = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  int lat;

  initial begin
    rst_n = 1'b1;
    bus.AS = 1'b1; bus.ADDR = '0; bus.FC = 3'b110; bus.ALO = '0; bus.DTACK_MFP = 1'b1;
    en_snap = '1; strobe_snap = '1;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_boot", bus.BOOT, 0);
    check("reset_strobes", {bus.DTACK, bus.BERR, bus.VPA}, 3'b111);

    // Boot overlay: eight ROM reads at 0, the ninth lands in SRAM bank 0.
    for (int i = 1; i <= 8; i++) begin
      run_cycle(7'h00, 3'b110, 3'd0, -1, 1'b1, lat);
      check("boot_rom_lat", lat, 3);
      check("boot_rom_en", en_snap, 8'h7F);
    end
    check("boot_set", bus.BOOT, 1);
    run_cycle(7'h00, 3'b110, 3'd0, -1, 1'b1, lat);
    check("ram0_lat", lat, 1);
    check("ram0_en", en_snap, 8'hFE);

    run_cycle(7'h20, 3'b101, 3'd0, -1, 1'b1, lat);   // 0x100000 -> bank 2
    check("ram2_lat", lat, 1);
    check("ram2_en", en_snap, 8'hFB);
    check("ram2_dtack_released", bus.DTACK, 1);

    run_cycle(7'h7F, 3'b110, 3'd0, -1, 1'b1, lat);   // ROM proper
    check("rom_lat", lat, 3);
    run_cycle(7'h7D, 3'b101, 3'd0, -1, 1'b1, lat);   // USB
    check("usb_lat", lat, 5);
    check("usb_en", en_snap, 8'hDF);
    run_cycle(7'h7C, 3'b101, 3'd0, -1, 1'b1, lat);   // serial
    check("ser_lat", lat, 5);
    check("ser_en", en_snap, 8'hEF);

    run_cycle(7'h7E, 3'b101, 3'd0, 11, 1'b1, lat);   // MFP, DTACK_MFP low after 10 clocks
    check("mfp_lat", lat, 11);
    check("mfp_strobe", strobe_snap, 3'b011);
    check("mfp_en", en_snap, 8'hBF);
    run_cycle(7'h7E, 3'b101, 3'd0, 64, 1'b1, lat);   // ack on the timeout edge wins
    check("mfp_edge_lat", lat, 64);
    check("mfp_edge_strobe", strobe_snap, 3'b011);
    run_cycle(7'h7E, 3'b101, 3'd0, 65, 1'b1, lat);   // one clock too late -> BERR
    check("mfp_late_strobe", strobe_snap, 3'b101);

    run_cycle(7'h60, 3'b101, 3'd0, -1, 1'b1, lat);   // 0x300000 unmapped
    check("unmapped_lat", lat, 64);
    check("unmapped_strobe", strobe_snap, 3'b101);
    check("unmapped_en", en_snap, 8'hFF);
    check("unmapped_berr_released", bus.BERR, 1);

    run_cycle(7'h00, 3'b111, 3'd5, 3, 1'b1, lat);    // IACK at MFP level
    check("iack_mfp_lat", lat, 3);
    check("iack_mfp_strobe", strobe_snap, 3'b011);
    check("iack_mfp_en", en_snap, 8'hBF);
    run_cycle(7'h00, 3'b111, 3'd2, -1, 1'b1, lat);   // autovectored level
    check("iack_auto_lat", lat, 1);
    check("iack_auto_strobe", strobe_snap, 3'b110);
    check("iack_auto_en", en_snap, 8'hFF);

    // Aborted ROM cycle: AS released before the wait states run out.
    @(posedge clk); #2;
    bus.ADDR = 7'h7F; bus.FC = 3'b110; bus.AS = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.AS = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("abort_no_dtack", bus.DTACK, 1);

    // Reset while DTACK is held low releases it immediately and restarts the overlay.
    run_cycle(7'h7F, 3'b110, 3'd0, -1, 1'b0, lat);
    check("pre_reset_dtack", bus.DTACK, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_strobes", {bus.DTACK, bus.BERR, bus.VPA}, 3'b111);
    check("rst_boot", bus.BOOT, 0);
    bus.AS = 1'b1;
    @(posedge clk); #2 rst_n = 1'b1;
    run_cycle(7'h20, 3'b110, 3'd0, -1, 1'b1, lat);
    check("post_rst_rom_lat", lat, 3);
    check("post_rst_rom_en", en_snap, 8'h7F);
    check("post_rst_boot", bus.BOOT, 0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

endmodule
